// File: rtl/reg_writeback_queue.sv
// Buffers execution results and drains them one per cycle onto the register file write port,
// forwarding pending values to readers. Define WBQ_COALESCE_EN to merge a result into a matching tail entry.
module reg_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         resVld,
   output logic                         resRdy,
   input  logic [ADDR_W-1:0]            resReg,
   input  logic [DATA_W-1:0]            resData,
   input  logic                         wbHold,
   output logic                         regWrite,
   output logic [ADDR_W-1:0]            wrReg,
   output logic [DATA_W-1:0]            wrData,
   input  logic [ADDR_W-1:0]            rdReg1,
   input  logic [ADDR_W-1:0]            rdReg2,
   output logic                         fwd1Hit,
   output logic [DATA_W-1:0]            fwd1Data,
   output logic                         fwd2Hit,
   output logic [DATA_W-1:0]            fwd2Data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] regMem  [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [PW-1:0]     rdPtr;
   logic [PW-1:0]     wrPtr;
   logic [PW-1:0]     tailPtr;
   logic [PW-1:0]     idx;
   logic              notFull;
   logic              popEn;
   logic              pushEn;
   logic              tailHit;

   assign notFull = (count < CW'(DEPTH));
   assign popEn   = (count != '0) && !wbHold;
   assign tailPtr = wrPtr - 1'b1;

`ifdef WBQ_COALESCE_EN
   // A tail that is also the head being popped this edge cannot be rewritten, so it falls back to a push.
   assign tailHit = resVld && (count != '0) && (resReg == regMem[tailPtr])
                    && !(popEn && (count == CW'(1)));
   assign resRdy  = notFull || tailHit;
`else
   assign tailHit = 1'b0;
   assign resRdy  = notFull;
`endif

   // Register 0 is hardwired in the register file, so its results are accepted but never stored.
   assign pushEn = resVld && resRdy && (resReg != '0) && !tailHit;

   // Storage array carries no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         regMem[wrPtr]  <= resReg;
         dataMem[wrPtr] <= resData;
      end
      if (tailHit) begin
         dataMem[tailPtr] <= resData;
      end
   end

   // Pointer, occupancy and registered write-port stage.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         count    <= '0;
         regWrite <= 1'b0;
         wrReg    <= '0;
         wrData   <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popEn) begin
            regWrite <= 1'b1;
            wrReg    <= regMem[rdPtr];
            wrData   <= dataMem[rdPtr];
            rdPtr    <= rdPtr + 1'b1;
         end else begin
            regWrite <= 1'b0;
         end
         count <= count + CW'(pushEn) - CW'(popEn);
      end
   end

   // Scan from output stage through oldest to youngest entry so the youngest match wins.
   always_comb begin
      fwd1Hit  = 1'b0;
      fwd1Data = '0;
      fwd2Hit  = 1'b0;
      fwd2Data = '0;
      idx      = '0;
      if (regWrite && (rdReg1 != '0) && (wrReg == rdReg1)) begin
         fwd1Hit  = 1'b1;
         fwd1Data = wrData;
      end
      if (regWrite && (rdReg2 != '0) && (wrReg == rdReg2)) begin
         fwd2Hit  = 1'b1;
         fwd2Data = wrData;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rdPtr + PW'(i);
         if ((CW'(i) < count) && (rdReg1 != '0) && (regMem[idx] == rdReg1)) begin
            fwd1Hit  = 1'b1;
            fwd1Data = dataMem[idx];
         end
         if ((CW'(i) < count) && (rdReg2 != '0) && (regMem[idx] == rdReg2)) begin
            fwd2Hit  = 1'b1;
            fwd2Data = dataMem[idx];
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic including resets.
module tb_reg_writeback_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } entry_t;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        resVld = 1'b0;
   logic        resRdy;
   logic [4:0]  resReg = '0;
   logic [31:0] resData = '0;
   logic        wbHold = 1'b0;
   logic        regWrite;
   logic [4:0]  wrReg;
   logic [31:0] wrData;
   logic [4:0]  rdReg1 = '0;
   logic [4:0]  rdReg2 = '0;
   logic        fwd1Hit;
   logic [31:0] fwd1Data;
   logic        fwd2Hit;
   logic [31:0] fwd2Data;
   logic [2:0]  count;

   int compared = 0;
   int mismatched = 0;

   entry_t      q[$];
   bit          modelValid = 0;
   logic        mRegWrite;
   logic [4:0]  mWrReg;
   logic [31:0] mWrData;
   int          mN;
   bit          mPop;
   bit          mHit;
   bit          mAcc;
   entry_t      mHead;
   int          holdLvl;

   reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .resetN(resetN), .resVld(resVld), .resRdy(resRdy),
      .resReg(resReg), .resData(resData), .wbHold(wbHold),
      .regWrite(regWrite), .wrReg(wrReg), .wrData(wrData),
      .rdReg1(rdReg1), .rdReg2(rdReg2),
      .fwd1Hit(fwd1Hit), .fwd1Data(fwd1Data),
      .fwd2Hit(fwd2Hit), .fwd2Data(fwd2Data),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Tail coalescing: same register as youngest entry, unless that entry leaves this edge.
   function automatic bit modelTailHit();
      bit h;
      h = 0;
`ifdef WBQ_COALESCE_EN
      h = resVld && (q.size() > 0) && (q[q.size()-1].r == resReg)
          && !((q.size() > 0) && !wbHold && (q.size() == 1));
`endif
      return h;
   endfunction

   function automatic bit modelRdy();
      return (q.size() < DEPTH) || modelTailHit();
   endfunction

   // Youngest pending entry wins, then the value currently being written.
   function automatic logic [32:0] modelFwd(input logic [4:0] rd);
      if (rd == 5'd0) return 33'd0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].r == rd) return {1'b1, q[i].d};
      end
      if (mRegWrite && mWrReg == rd) return {1'b1, mWrData};
      return 33'd0;
   endfunction

   always @(posedge clk) begin
      if (!resetN) begin
         q.delete();
         mRegWrite  = 1'b0;
         mWrReg     = '0;
         mWrData    = '0;
         modelValid = 1;
      end else if (modelValid) begin
         mN   = q.size();
         mPop = (mN > 0) && !wbHold;
         mHit = modelTailHit();
         mAcc = resVld && modelRdy();
         if (mPop) mHead = q[0];
         if (mAcc && mHit) q[mN-1].d = resData;
         if (mPop) begin
            void'(q.pop_front());
            mRegWrite = 1'b1;
            mWrReg    = mHead.r;
            mWrData   = mHead.d;
         end else begin
            mRegWrite = 1'b0;
         end
         if (mAcc && !mHit && resReg != 5'd0) q.push_back('{r: resReg, d: resData});
      end
   end

   always @(negedge clk) begin
      logic [32:0] f1;
      logic [32:0] f2;
      if (modelValid) begin
         f1 = modelFwd(rdReg1);
         f2 = modelFwd(rdReg2);
         checkOutput("resRdy",   {31'd0, resRdy},   {31'd0, modelRdy()});
         checkOutput("regWrite", {31'd0, regWrite}, {31'd0, mRegWrite});
         checkOutput("wrReg",    {27'd0, wrReg},    {27'd0, mWrReg});
         checkOutput("wrData",   wrData,            mWrData);
         checkOutput("count",    {29'd0, count},    q.size());
         checkOutput("fwd1Hit",  {31'd0, fwd1Hit},  {31'd0, f1[32]});
         checkOutput("fwd1Data", fwd1Data,          f1[31:0]);
         checkOutput("fwd2Hit",  {31'd0, fwd2Hit},  {31'd0, f2[32]});
         checkOutput("fwd2Data", fwd2Data,          f2[31:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic vld, input logic [4:0] r, input logic [31:0] d, input logic hold);
      resVld  = vld;
      resReg  = r;
      resData = d;
      wbHold  = hold;
      tick();
   endtask

   initial begin
      // Reset held for two edges
      tick();
      checkOutput("rst regWrite", {31'd0, regWrite}, 32'd0);
      tick();
      checkOutput("rst count", {29'd0, count}, 32'd0);
      checkOutput("rst wrData", wrData, 32'd0);
      resetN = 1'b1;

      // Single write latency
      applyStimulus(1'b1, 5'd5, 32'h0000_0101, 1'b0);
      resVld = 1'b0;
      checkOutput("lat regWrite N", {31'd0, regWrite}, 32'd0);
      tick();
      checkOutput("lat regWrite N+1", {31'd0, regWrite}, 32'd1);
      checkOutput("lat wrReg", {27'd0, wrReg}, 32'd5);
      checkOutput("lat wrData", wrData, 32'h0000_0101);
      tick();
      tick();

      // Fill and stall, then drain in order
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i), 32'h11 * i, 1'b1);
      resVld = 1'b0;
      #1;
      checkOutput("fill count", {29'd0, count}, 32'd4);
      checkOutput("fill resRdy", {31'd0, resRdy}, 32'd0);
      checkOutput("fill regWrite", {31'd0, regWrite}, 32'd0);
      wbHold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput("drain regWrite", {31'd0, regWrite}, 32'd1);
         checkOutput("drain wrReg", {27'd0, wrReg}, i);
         checkOutput("drain wrData", wrData, 32'h11 * i);
      end
      checkOutput("drain count", {29'd0, count}, 32'd0);
      tick();

      // Register 0 is dropped
      rdReg1 = 5'd0;
      applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
      resVld = 1'b0;
      checkOutput("r0 count", {29'd0, count}, 32'd0);
      tick();
      checkOutput("r0 regWrite", {31'd0, regWrite}, 32'd0);
      checkOutput("r0 fwd1Hit", {31'd0, fwd1Hit}, 32'd0);

      // Forwarding priority
      rdReg1 = 5'd7;
      rdReg2 = 5'd8;
      applyStimulus(1'b1, 5'd7, 32'hA, 1'b1);
      applyStimulus(1'b1, 5'd7, 32'hB, 1'b1);
      resVld = 1'b0;
      #1;
      checkOutput("fwd1Hit", {31'd0, fwd1Hit}, 32'd1);
      checkOutput("fwd1Data", fwd1Data, 32'hB);
      checkOutput("fwd2Hit", {31'd0, fwd2Hit}, 32'd0);
      checkOutput("fwd2Data", fwd2Data, 32'h0);
      wbHold = 1'b0;
      repeat (4) tick();

      // Push and pop on the same edge, then mid-operation reset
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b1);
      applyStimulus(1'b1, 5'd10, 32'hAA, 1'b1);
      applyStimulus(1'b1, 5'd11, 32'hBB, 1'b0);
      resVld = 1'b0;
      wbHold = 1'b1;
      checkOutput("pushpop count", {29'd0, count}, 32'd2);
      checkOutput("pushpop regWrite", {31'd0, regWrite}, 32'd1);
      checkOutput("pushpop wrReg", {27'd0, wrReg}, 32'd9);
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      wbHold = 1'b0;
      checkOutput("midrst regWrite", {31'd0, regWrite}, 32'd0);
      checkOutput("midrst count", {29'd0, count}, 32'd0);
      tick();
      checkOutput("midrst no write", {31'd0, regWrite}, 32'd0);
      tick();

      // Same register twice while stalled
      rdReg1 = 5'd3;
      applyStimulus(1'b1, 5'd3, 32'h1, 1'b1);
      applyStimulus(1'b1, 5'd3, 32'h2, 1'b1);
      resVld = 1'b0;
      #1;
      checkOutput("coal fwdData", fwd1Data, 32'h2);
`ifdef WBQ_COALESCE_EN
      checkOutput("coal count", {29'd0, count}, 32'd1);
`else
      checkOutput("coal count", {29'd0, count}, 32'd2);
`endif
      wbHold = 1'b0;
      tick();
      checkOutput("coal wr1 regWrite", {31'd0, regWrite}, 32'd1);
`ifdef WBQ_COALESCE_EN
      checkOutput("coal wr1 data", wrData, 32'h2);
      tick();
      checkOutput("coal wr2 regWrite", {31'd0, regWrite}, 32'd0);
`else
      checkOutput("coal wr1 data", wrData, 32'h1);
      tick();
      checkOutput("coal wr2 regWrite", {31'd0, regWrite}, 32'd1);
      checkOutput("coal wr2 data", wrData, 32'h2);
`endif
      tick();

      // Randomized traffic with varying stall pressure and occasional resets
      for (int it = 0; it < 3000; it++) begin
         holdLvl = (it / 150) % 10;
         resetN  = ($urandom_range(0, 199) != 0);
         rdReg1  = 5'($urandom_range(0, 7));
         rdReg2  = 5'($urandom_range(0, 7));
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 9) < holdLvl));
      end
      resetN = 1'b1;
      resVld = 1'b0;
      wbHold = 1'b0;
      repeat (8) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
